// File: rtl/kme_ib_tlast_gen_pkg.sv
// -----------------------------------------------------------------------------
// kme_ib_tlast_gen_pkg
// Shared types for the inbound KME tlast generator:
//   - kme_ib_state_e : TLV parser states
//   - SOT_BIT/EOT_BIT: tuser bit positions for start/end of TLV
//   - kme_ib_beat_t  : one stream beat plus its generated tlast, as it is
//                      stored in the skid buffer
// The KME_*_W widths must match the width parameters of kme_ib_tlast_gen.
// -----------------------------------------------------------------------------
package kme_ib_tlast_gen_pkg;

  localparam int unsigned KME_DATA_W = 64;
  localparam int unsigned KME_STRB_W = 8;
  localparam int unsigned KME_USER_W = 8;
  localparam int unsigned KME_TID_W  = 1;

  localparam int unsigned SOT_BIT = 0;
  localparam int unsigned EOT_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MEGA      = 3'd1,
    ST_WAIT_GUID = 3'd2,
    ST_GUID      = 3'd3,
    ST_OTHER     = 3'd4
  } kme_ib_state_e;

  typedef struct packed {
    logic [KME_DATA_W-1:0] tdata;
    logic [KME_STRB_W-1:0] tstrb;
    logic [KME_USER_W-1:0] tuser;
    logic [KME_TID_W-1:0]  tid;
    logic                  tlast;
  } kme_ib_beat_t;

endpackage

// File: rtl/kme_axis_skid.sv
// -----------------------------------------------------------------------------
// kme_axis_skid
// Two-entry register skid buffer. The head register drives the output
// directly; the tail register absorbs one beat when the consumer stalls.
// Ready is registered: it is high iff at most one entry is held after the
// current cycle.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   s_valid_i/s_ready_o   upstream handshake, s_data_i upstream payload
//   m_valid_o/m_ready_i   downstream handshake, m_data_o downstream payload
// -----------------------------------------------------------------------------
module kme_axis_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         rdy_q, rdy_d;
  logic         push_s, pop_s;

  assign push_s = s_valid_i & rdy_q;
  assign pop_s  = (cnt_q != 2'd0) & m_ready_i;

  // Occupancy and entry movement; push cannot occur when two entries are held.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case (cnt_q)
      2'd0: begin
        if (push_s) begin
          head_d = s_data_i;
          cnt_d  = 2'd1;
        end else begin
          cnt_d  = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          head_d = s_data_i;
        end else if (push_s) begin
          tail_d = s_data_i;
          cnt_d  = 2'd2;
        end else if (pop_s) begin
          cnt_d  = 2'd0;
        end else begin
          cnt_d  = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          head_d = tail_q;
          cnt_d  = 2'd1;
        end else begin
          cnt_d  = 2'd2;
        end
      end
      default: cnt_d = 2'd0;
    endcase
    rdy_d = (cnt_d != 2'd2);
  end

  // Skid state registers; ready stays low while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      rdy_q  <= rdy_d;
    end
  end

  assign s_ready_o = rdy_q;
  assign m_valid_o = (cnt_q != 2'd0);
  assign m_data_o  = head_q;

endmodule

// File: rtl/kme_ib_tlast_gen.sv
// -----------------------------------------------------------------------------
// kme_ib_tlast_gen
// Inbound framing stage in front of cr_kme. Parses TLV boundaries on the
// host beat stream and generates kme_ib_tlast on the last beat of each KME
// command (a plain mega TLV, or a mega TLV plus its trailing GUID TLV).
// Payload passes through unchanged, one cycle late, via a 2-entry skid.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   s_t*              upstream AXI4-Stream (tuser bit0 = SoT, bit1 = EoT)
//   kme_ib_t*         downstream AXI4-Stream to cr_kme, plus generated tlast
//   frame_err         sticky protocol error flag
//   cmd_cnt, err_cnt  statistics, only with KME_IB_TLAST_GEN_STATS_EN defined;
//                     otherwise tied to zero
// -----------------------------------------------------------------------------
module kme_ib_tlast_gen
  import kme_ib_tlast_gen_pkg::*;
#(
  parameter int unsigned DATA_W        = KME_DATA_W,
  parameter int unsigned STRB_W        = KME_STRB_W,
  parameter int unsigned USER_W        = KME_USER_W,
  parameter int unsigned TID_W         = KME_TID_W,
  parameter logic [7:0]  MEGA_MIN_TYPE = 8'd21,
  parameter logic [7:0]  GUID_TYPE     = 8'd10,
  parameter int unsigned GUID_FLAG_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [STRB_W-1:0] s_tstrb,
  input  logic [USER_W-1:0] s_tuser,
  input  logic [TID_W-1:0]  s_tid,
  output logic              kme_ib_tvalid,
  input  logic              kme_ib_tready,
  output logic [DATA_W-1:0] kme_ib_tdata,
  output logic [STRB_W-1:0] kme_ib_tstrb,
  output logic [USER_W-1:0] kme_ib_tuser,
  output logic [TID_W-1:0]  kme_ib_tid,
  output logic              kme_ib_tlast,
  output logic              frame_err,
  output logic [31:0]       cmd_cnt,
  output logic [15:0]       err_cnt
);

  kme_ib_state_e state_q, state_d;
  logic          guid_pend_q, guid_pend_d;
  logic          idx1_q, idx1_d;       // next MEGA beat is beat index 1
  logic          frame_err_q;
  logic          acc_s, sot_s, eot_s, mega_s, gp_s, tlast_s, err_s, pop_s;
  logic [7:0]    type_s;
  kme_ib_beat_t  in_beat_s, out_beat_s;

  assign acc_s  = s_tvalid & s_tready;
  assign sot_s  = s_tuser[SOT_BIT];
  assign eot_s  = s_tuser[EOT_BIT];
  assign type_s = s_tdata[7:0];
  assign mega_s = (type_s >= MEGA_MIN_TYPE);
  // GUID flag as seen by this beat: live on beat 1, latched afterwards.
  assign gp_s   = idx1_q ? s_tdata[GUID_FLAG_BIT] : guid_pend_q;

  // TLV parser: next state, tlast and protocol error for the accepted beat.
  always_comb begin
    state_d     = state_q;
    guid_pend_d = guid_pend_q;
    idx1_d      = idx1_q;
    tlast_s     = 1'b0;
    err_s       = 1'b0;
    if (acc_s) begin
      if (sot_s && (state_q != ST_WAIT_GUID)) begin
        // New TLV; outside IDLE this abandons an unfinished TLV.
        err_s       = (state_q != ST_IDLE);
        guid_pend_d = 1'b0;
        if (mega_s) begin
          tlast_s = eot_s;
          idx1_d  = ~eot_s;
          state_d = eot_s ? ST_IDLE : ST_MEGA;
        end else begin
          idx1_d  = 1'b0;
          state_d = eot_s ? ST_IDLE : ST_OTHER;
        end
      end else begin
        case (state_q)
          ST_IDLE: err_s = 1'b1;
          ST_WAIT_GUID: begin
            if (sot_s) begin
              guid_pend_d = 1'b0;
              if (type_s == GUID_TYPE) begin
                tlast_s = eot_s;
                state_d = eot_s ? ST_IDLE : ST_GUID;
              end else begin
                err_s   = 1'b1;
                state_d = eot_s ? ST_IDLE : ST_OTHER;
              end
            end else begin
              err_s = 1'b1;
            end
          end
          ST_MEGA: begin
            idx1_d      = 1'b0;
            guid_pend_d = gp_s;
            if (eot_s) begin
              tlast_s = ~gp_s;
              state_d = gp_s ? ST_WAIT_GUID : ST_IDLE;
            end else begin
              state_d = ST_MEGA;
            end
          end
          ST_GUID: begin
            if (eot_s) begin
              tlast_s = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_GUID;
            end
          end
          ST_OTHER: begin
            if (eot_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_OTHER;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Parser state and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      guid_pend_q <= 1'b0;
      idx1_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      guid_pend_q <= guid_pend_d;
      idx1_q      <= idx1_d;
      frame_err_q <= frame_err_q | err_s;
    end
  end

  assign in_beat_s = '{tdata: s_tdata, tstrb: s_tstrb, tuser: s_tuser,
                       tid: s_tid, tlast: tlast_s};

  kme_axis_skid #(.W($bits(kme_ib_beat_t))) u_skid (
    .clk       (clk),
    .rst       (rst),
    .s_valid_i (s_tvalid),
    .s_ready_o (s_tready),
    .s_data_i  (in_beat_s),
    .m_valid_o (kme_ib_tvalid),
    .m_ready_i (kme_ib_tready),
    .m_data_o  (out_beat_s)
  );

  assign kme_ib_tdata = out_beat_s.tdata;
  assign kme_ib_tstrb = out_beat_s.tstrb;
  assign kme_ib_tuser = out_beat_s.tuser;
  assign kme_ib_tid   = out_beat_s.tid;
  assign kme_ib_tlast = out_beat_s.tlast;
  assign frame_err    = frame_err_q;
  assign pop_s        = kme_ib_tvalid & kme_ib_tready;

`ifdef KME_IB_TLAST_GEN_STATS_EN
  logic [31:0] cmd_cnt_q;
  logic [15:0] err_cnt_q;

  // Command counter (wraps) and saturating error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_cnt_q <= 32'd0;
      err_cnt_q <= 16'd0;
    end else begin
      if (pop_s && kme_ib_tlast) begin
        cmd_cnt_q <= cmd_cnt_q + 32'd1;
      end
      if (err_s && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign cmd_cnt = cmd_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  logic unused_pop_s;
  assign unused_pop_s = pop_s;
  assign cmd_cnt      = 32'd0;
  assign err_cnt      = 16'd0;
`endif

endmodule

// File: tb/tb_kme_ib_tlast_gen.sv
// -----------------------------------------------------------------------------
// tb_kme_ib_tlast_gen
// Random and directed TLV streams; expected tlast per beat is derived at
// TLV level (command = mega TLV, or mega TLV with GUID flag plus GUID TLV),
// and skid occupancy is tracked from observed handshakes.
// -----------------------------------------------------------------------------
module tb_kme_ib_tlast_gen;
  import kme_ib_tlast_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] s_tdata = 64'd0;
  logic [7:0]  s_tstrb = 8'd0;
  logic [7:0]  s_tuser = 8'd0;
  logic [0:0]  s_tid = 1'b0;
  logic        kme_ib_tvalid;
  logic        kme_ib_tready = 1'b0;
  logic [63:0] kme_ib_tdata;
  logic [7:0]  kme_ib_tstrb;
  logic [7:0]  kme_ib_tuser;
  logic [0:0]  kme_ib_tid;
  logic        kme_ib_tlast;
  logic        frame_err;
  logic [31:0] cmd_cnt;
  logic [15:0] err_cnt;

  kme_ib_tlast_gen dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tstrb(s_tstrb), .s_tuser(s_tuser), .s_tid(s_tid),
    .kme_ib_tvalid(kme_ib_tvalid), .kme_ib_tready(kme_ib_tready),
    .kme_ib_tdata(kme_ib_tdata), .kme_ib_tstrb(kme_ib_tstrb),
    .kme_ib_tuser(kme_ib_tuser), .kme_ib_tid(kme_ib_tid),
    .kme_ib_tlast(kme_ib_tlast), .frame_err(frame_err),
    .cmd_cnt(cmd_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  kme_ib_beat_t exp_q[$];
  int occ = 0;
  int exp_err = 0;
  int exp_cmd = 0;
  bit expect_guid = 1'b0;
  bit trunc_pending = 1'b0;
  int tready_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 stalled

  task automatic check_val(input string tag, input logic [127:0] obs,
                           input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream ready pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0: kme_ib_tready = 1'b1;
        1: kme_ib_tready = ~kme_ib_tready;
        2: kme_ib_tready = 1'($urandom_range(0, 1));
        default: kme_ib_tready = 1'b0;
      endcase
    end
  end

  // Output monitor: reset values, occupancy, stall stability, scoreboard.
  initial begin
    kme_ib_beat_t obs, prev, e;
    bit stall_prev;
    bit skip;
    stall_prev = 1'b0;
    skip = 1'b1;
    prev = '0;
    forever begin
      @(negedge clk);
      obs = '{tdata: kme_ib_tdata, tstrb: kme_ib_tstrb, tuser: kme_ib_tuser,
              tid: kme_ib_tid, tlast: kme_ib_tlast};
      if (rst) begin
        check_val("rst_out", {kme_ib_tvalid, obs}, '0);
        check_val("rst_status", {s_tready, frame_err, cmd_cnt, err_cnt}, '0);
        exp_q.delete();
        occ = 0;
        skip = 1'b1;
        stall_prev = 1'b0;
      end else begin
        if (!skip) check_val("s_tready_occ", s_tready, (occ <= 1));
        skip = 1'b0;
        check_val("tvalid_occ", kme_ib_tvalid, (occ != 0));
        if (stall_prev) check_val("stall_hold", obs, prev);
        if (kme_ib_tvalid && kme_ib_tready) begin
          if (exp_q.size() == 0) begin
            check_val("unexpected_beat", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check_val("beat_data", {obs.tdata, obs.tstrb, obs.tuser, obs.tid},
                      {e.tdata, e.tstrb, e.tuser, e.tid});
            check_val("tlast", obs.tlast, e.tlast);
          end
        end
        stall_prev = kme_ib_tvalid && !kme_ib_tready;
        prev = obs;
        occ = occ + ((s_tvalid && s_tready) ? 1 : 0)
                  - ((kme_ib_tvalid && kme_ib_tready) ? 1 : 0);
      end
    end
  end

  task automatic send_beat(input kme_ib_beat_t b);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = b.tdata;
    s_tstrb  = b.tstrb;
    s_tuser  = b.tuser;
    s_tid    = b.tid;
    forever begin
      @(negedge clk);
      if (s_tready) begin
        exp_q.push_back(b);
        break;
      end
      n++;
      if (n > 100) begin
        check_val("s_tready_timeout", 1'b0, 1'b1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One TLV; expected closing decided from the command rules at TLV level.
  task automatic send_tlv(input logic [7:0] typ, input int len,
                          input bit flag, input bit trunc);
    kme_ib_beat_t b;
    bit closes;
    closes = 1'b0;
    if (trunc_pending) exp_err++;
    trunc_pending = trunc;
    if (expect_guid) begin
      expect_guid = 1'b0;
      if (typ == 8'd10) closes = !trunc;
      else exp_err++;
    end else if (typ >= 8'd21) begin
      if ((len >= 2) && flag) expect_guid = !trunc;
      else closes = !trunc;
    end
    if (closes) exp_cmd++;
    for (int i = 0; i < len; i++) begin
      b.tdata = {$urandom(), $urandom()};
      b.tstrb = 8'($urandom());
      b.tuser = 8'($urandom());
      b.tid   = 1'($urandom());
      if (i == 0) b.tdata[7:0] = typ;
      if (i == 1) b.tdata[4] = flag;
      b.tuser[0] = (i == 0);
      b.tuser[1] = (i == len - 1) && !trunc;
      b.tlast    = closes && (i == len - 1);
      send_beat(b);
    end
  endtask

  task automatic send_orphan();
    kme_ib_beat_t b;
    b.tdata = {$urandom(), $urandom()};
    b.tstrb = 8'($urandom());
    b.tuser = 8'($urandom());
    b.tid   = 1'($urandom());
    b.tuser[0] = 1'b0;
    b.tlast = 1'b0;
    exp_err++;
    send_beat(b);
  endtask

  task automatic random_items(input int n);
    int r;
    logic [7:0] typ;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8 && !trunc_pending) begin
        send_orphan();
      end else begin
        if (expect_guid && ($urandom_range(0, 4) != 0)) typ = 8'd10;
        else if (r < 50) typ = 8'($urandom_range(21, 255));
        else if (r < 65) typ = 8'd10;
        else typ = 8'($urandom_range(0, 20));
        send_tlv(typ, $urandom_range(1, 5), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 8));
      end
    end
    if (trunc_pending) send_tlv(8'd5, 2, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check_val("drain_timeout", (exp_q.size() == 0), 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check_val({tag, "_frame_err"}, frame_err, (exp_err != 0));
`ifdef KME_IB_TLAST_GEN_STATS_EN
    check_val({tag, "_cmd_cnt"}, cmd_cnt, exp_cmd);
    check_val({tag, "_err_cnt"}, err_cnt, (exp_err > 65535) ? 65535 : exp_err);
`else
    check_val({tag, "_cmd_cnt"}, cmd_cnt, 32'd0);
    check_val({tag, "_err_cnt"}, err_cnt, 16'd0);
`endif
  endtask

  initial begin
    kme_ib_beat_t b;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tready_mode = 0;
    @(posedge clk);
    #1;

    send_tlv(8'd21, 4, 1'b0, 1'b0);
    drain();
    check_status("mega_plain");

    send_tlv(8'd21, 4, 1'b1, 1'b0);
    send_tlv(8'd10, 3, 1'b0, 1'b0);
    drain();
    check_status("mega_guid");

    send_tlv(8'd5, 2, 1'b0, 1'b0);
    send_tlv(8'd5, 1, 1'b0, 1'b0);
    drain();
    check_status("non_mega");

    send_tlv(8'd30, 3, 1'b1, 1'b0);
    send_tlv(8'd7, 2, 1'b0, 1'b0);
    drain();
    check_status("wrong_guid");

    tready_mode = 1;
    random_items(12);
    drain();
    check_status("toggle_ready");

    tready_mode = 2;
    random_items(150);
    drain();
    check_status("random_stream");

    // Reset mid-command with the first mega beat still held in the skid.
    tready_mode = 3;
    b.tdata = {$urandom(), $urandom()};
    b.tdata[7:0] = 8'd40;
    b.tstrb = 8'hFF;
    b.tuser = 8'h01;
    b.tid   = 1'b0;
    b.tlast = 1'b0;
    send_beat(b);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_err = 0;
    exp_cmd = 0;
    expect_guid = 1'b0;
    trunc_pending = 1'b0;
    tready_mode = 0;
    @(posedge clk);
    #1;
    check_status("post_reset");
    send_tlv(8'd21, 2, 1'b0, 1'b0);
    drain();
    check_status("after_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kme_ib_tlast_gen.md
# kme_ib_tlast_gen

Inbound AXI4-Stream framing stage placed directly upstream of `cr_kme`. It takes the raw TLV beat stream from the host and forwards it to the `kme_ib_*` port. Along the way it parses TLV boundaries (tuser SoT/EoT, TLV type byte, mega-TLV GUID flag) and generates `kme_ib_tlast` on the last beat of each KME command. This moves the tlast-insertion rule into RTL; it no longer depends on bench software. Data, strobe, user and tid pass through unmodified with one cycle of latency behind a 2-entry skid buffer.

## Interface
- `DATA_W`, 64, tdata width
- `STRB_W`, 8, tstrb width
- `USER_W`, 8, tuser width; bit 0 = SoT, bit 1 = EoT
- `TID_W`, 1, tid width
- `MEGA_MIN_TYPE`, 21, TLV type codes ≥ this are mega TLVs
- `GUID_TYPE`, 10, GUID TLV type code
- `GUID_FLAG_BIT`, 4, bit in mega-TLV beat 1 meaning "GUID TLV follows"
- clk  in  1  sole clock; one clock, all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- s_tvalid  in  1  upstream valid
- s_tready  out  1  upstream ready
- s_tdata  in  DATA_W  upstream data
- s_tstrb  in  STRB_W  upstream strobe
- s_tuser  in  USER_W  upstream user (SoT/EoT)
- s_tid  in  TID_W  upstream id
- kme_ib_tvalid  out  1  to `cr_kme`
- kme_ib_tready  in  1  from `cr_kme`
- kme_ib_tdata  out  DATA_W  passthrough data
- kme_ib_tstrb  out  STRB_W  passthrough strobe
- kme_ib_tuser  out  USER_W  passthrough user
- kme_ib_tid  out  TID_W  passthrough id
- kme_ib_tlast  out  1  generated last-beat-of-command
- frame_err  out  1  sticky protocol error; cleared only by rst
- cmd_cnt  out  32  commands closed with tlast (STATS only)
- err_cnt  out  16  protocol errors, saturating (STATS only)

## Operation
- A beat is accepted when s_tvalid&&s_tready. The parser updates on accepted beats only.
- Beat type is `s_tdata[7:0]` on an SoT beat.
- FSM states:
  - IDLE: expects SoT. Mega type → MEGA (beat index 0). Any other type → OTHER.
  - MEGA: beat index 1 latches `guid_pend = s_tdata[GUID_FLAG_BIT]`. On EoT, tlast=1 if !guid_pend → IDLE; otherwise tlast=0 → WAIT_GUID.
  - WAIT_GUID: expects SoT with type GUID_TYPE → GUID. SoT of any other type sets the error → OTHER.
  - GUID: on EoT, tlast=1 → IDLE.
  - OTHER: on EoT, tlast=0 → IDLE.
- Single-beat TLV (SoT and EoT on the same beat) applies both rules in one cycle.
  - Single-beat mega TLV: guid_pend=0, so tlast=1.
  - Single-beat GUID in WAIT_GUID: tlast=1.
- Protocol errors set frame_err and increment err_cnt:
  - SoT while in MEGA, GUID or OTHER: restart parsing on this beat as if in IDLE.
  - Non-SoT beat in IDLE or WAIT_GUID: tlast=0, stay in state.
  - Wrong TLV type in WAIT_GUID: as defined above.
- tlast is computed combinationally from the input beat and stored alongside it in the skid entry.

## Timing
- Reset values: kme_ib_tvalid=0, kme_ib_tlast=0, all kme_ib data fields=0, s_tready=0, frame_err=0, counters=0, FSM=IDLE, guid_pend=0.
- s_tready goes to 1 on the first clk edge after rst deasserts.
- Latency is 1 cycle from input acceptance to kme_ib_tvalid.
- Full throughput: 1 beat/cycle while kme_ib_tready=1.
- s_tready is registered. It is 1 iff the skid holds ≤1 entry after the current cycle.
- No bubbles while kme_ib_tready=1.
- Output holds stable while kme_ib_tvalid && !kme_ib_tready (AXI rule).
- Simultaneous push and pop on a 1-entry skid: occupancy stays at 1.
- Asserting rst mid-command discards both skid entries and returns to IDLE immediately; the partial command is not closed.
- cmd_cnt wraps at 2^32. err_cnt saturates at 0xFFFF.

## Configuration
- Macro `KME_IB_TLAST_GEN_STATS_EN`.
- Defined: cmd_cnt and err_cnt are implemented. cmd_cnt increments when a tlast beat is accepted on the output (kme_ib_tvalid && kme_ib_tready && kme_ib_tlast).
- Undefined: counters are absent and both ports are tied to 0. frame_err is always present.

## Structure
- Package `kme_ib_tlast_gen_pkg` holds:
  - FSM state enum (IDLE, MEGA, WAIT_GUID, GUID, OTHER)
  - tuser bit localparams (SOT_BIT=0, EOT_BIT=1)
  - packed beat struct {tdata, tstrb, tuser, tid, tlast}
- Sub-module `kme_axis_skid`: 2-entry register skid, parameterised on the struct width, registered ready.

## Test plan
- Mega TLV type 21, 4 beats, beat1 tdata=0x00 → tlast=1 on beat 3 only; cmd_cnt=1.
- Mega TLV with beat1 tdata=0x10, then GUID TLV type 10 of 3 beats → tlast=0 through mega EoT, tlast=1 on GUID beat 2; cmd_cnt=1.
- Non-mega TLV type 5, 2 beats, with SoT/EoT on a single beat → no tlast, frame_err=0.
- GUID flag set but next TLV is type 7 → frame_err=1, err_cnt=1, no tlast.
- kme_ib_tready toggling 1/0 every cycle over 20 beats → output beat sequence identical to input, no loss/duplication, s_tready never asserts with 2 entries full.
- rst pulse after beat 1 of a mega TLV, then a fresh 2-beat mega TLV → all outputs at reset values, tlast=1 on the new TLV's beat 1.
